// File: rtl/fir_mc_engine_pkg.sv
// Shared types and helpers for the multi-channel serial-MAC FIR engine.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} fir_state_t;

    function automatic int fir_acc_w(input int bit_width, input int order);
        return 2 * bit_width + $clog2(order);
    endfunction

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mc_engine_ch_delay_bank.sv
// Per-channel sample delay lines: shift-in write port, combinational tap read.
module fir_ch_delay_bank #(
    parameter int NUM_CH    = 2,
    parameter int FIR_ORDER = 8,
    parameter int BIT_WIDTH = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAP_W    = $clog2(FIR_ORDER)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [CH_W-1:0]             i_push_ch,
    input  logic signed [BIT_WIDTH-1:0] i_push_data,
    input  logic                        i_flush,
    input  logic [CH_W-1:0]             i_rd_ch,
    input  logic [TAP_W-1:0]            i_rd_tap,
    output logic signed [BIT_WIDTH-1:0] o_rd_data
);

    logic signed [BIT_WIDTH-1:0] r_mem [NUM_CH][FIR_ORDER];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                for (int unsigned t = 0; t < FIR_ORDER; t++)
                    r_mem[c][t] <= '0;
        end else if (i_flush) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                for (int unsigned t = 0; t < FIR_ORDER; t++)
                    r_mem[c][t] <= '0;
        end else if (i_push) begin
            r_mem[i_push_ch][0] <= i_push_data;
            for (int unsigned t = 1; t < FIR_ORDER; t++)
                r_mem[i_push_ch][t] <= r_mem[i_push_ch][t-1];
        end
    end

    assign o_rd_data = r_mem[i_rd_ch][i_rd_tap];

endmodule

// File: rtl/fir_mc_engine.sv
// Multi-channel serial-MAC FIR engine with shared multiplier and writable coefficients.
// Optional output saturation and sticky sat_flag port enabled by `define FIR_SAT_EN.
module fir_mc_engine
    import fir_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int FIR_ORDER  = 8,
    parameter int NUM_CH     = 2,
    parameter int OUT_WIDTH  = 16,
    parameter int COEF_FRAC  = 15,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAP_W     = $clog2(FIR_ORDER)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH_W-1:0]             in_ch,
    input  logic signed [BIT_WIDTH-1:0] in_data,
    input  logic                        coef_we,
    input  logic [TAP_W-1:0]            coef_addr,
    input  logic signed [BIT_WIDTH-1:0] coef_data,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CH_W-1:0]             out_ch,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        busy,
    output logic                        ch_err
`ifdef FIR_SAT_EN
    ,
    output logic                        sat_flag
`endif
);

    localparam int ACC_W = fir_acc_w(BIT_WIDTH, FIR_ORDER);
    localparam int PW    = 2 * BIT_WIDTH;

    fir_state_t                  r_state, w_next;
    logic [TAP_W-1:0]            r_cnt;
    logic                        r_drain;
    logic [CH_W-1:0]             r_ch;
    logic signed [BIT_WIDTH-1:0] r_coef [FIR_ORDER];
    logic signed [BIT_WIDTH-1:0] r_x, r_c;
    logic signed [PW-1:0]        r_prod;
    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_ch_err;

    logic                        w_ch_ok, w_hs, w_push;
    logic signed [BIT_WIDTH-1:0] w_rd;
    logic signed [PW-1:0]        w_x_ext, w_c_ext;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic [OUT_WIDTH-1:0]        w_scaled;

    assign w_ch_ok = 32'(in_ch) < 32'(NUM_CH);
    assign w_hs    = in_valid && (r_state == IDLE) && !clear;
    assign w_push  = w_hs && w_ch_ok;
    assign ch_err  = r_ch_err;

    fir_ch_delay_bank #(
        .NUM_CH    (NUM_CH),
        .FIR_ORDER (FIR_ORDER),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_ch   (in_ch),
        .i_push_data (in_data),
        .i_flush     (clear),
        .i_rd_ch     (r_ch),
        .i_rd_tap    (r_cnt),
        .o_rd_data   (w_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && w_ch_ok) w_next = MAC;
            end
            MAC:   if (r_cnt == TAP_W'(FIR_ORDER - 1)) w_next = DRAIN;
            DRAIN: if (r_drain) w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < FIR_ORDER; k++) r_coef[k] <= '0;
        end else if (coef_we && r_state == IDLE) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    assign w_x_ext    = PW'(r_x);
    assign w_c_ext    = PW'(r_c);
    assign w_acc_next = r_acc + ACC_W'(r_prod);

`ifdef FIR_SAT_EN
    logic signed [63:0] w_shift64, w_sat64;
    logic               w_sat_hit, r_sat_flag;

    assign w_shift64 = 64'(w_acc_next >>> COEF_FRAC);
    assign w_sat64   = sat_to(w_shift64, OUT_WIDTH);
    assign w_sat_hit = (w_sat64 != w_shift64);
    assign w_scaled  = OUT_WIDTH'(w_sat64);
    assign sat_flag  = r_sat_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      r_sat_flag <= 1'b0;
        else if (clear)                                r_sat_flag <= 1'b0;
        else if (r_state == DRAIN && r_drain && w_sat_hit) r_sat_flag <= 1'b1;
    end
`else
    assign w_scaled = OUT_WIDTH'(w_acc_next >>> COEF_FRAC);
`endif

    // Operand fetch -> product -> accumulate; the last product lands on the final DRAIN edge,
    // so the output is taken from w_acc_next rather than r_acc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_drain  <= 1'b0;
            r_ch     <= '0;
            r_x      <= '0;
            r_c      <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_ch_err <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
        end else if (clear) begin
            r_cnt    <= '0;
            r_drain  <= 1'b0;
            r_x      <= '0;
            r_c      <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_ch_err <= 1'b0;
        end else begin
            r_ch_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_ch    <= in_ch;
                        r_cnt   <= '0;
                        r_drain <= 1'b0;
                        r_x     <= '0;
                        r_c     <= '0;
                        r_prod  <= '0;
                        r_acc   <= '0;
                    end else if (w_hs) begin
                        r_ch_err <= 1'b1;
                    end
                end
                MAC: begin
                    r_x    <= w_rd;
                    r_c    <= r_coef[r_cnt];
                    r_prod <= w_x_ext * w_c_ext;
                    r_acc  <= w_acc_next;
                    if (r_cnt != TAP_W'(FIR_ORDER - 1)) r_cnt <= r_cnt + 1'b1;
                end
                DRAIN: begin
                    r_prod  <= w_x_ext * w_c_ext;
                    r_acc   <= w_acc_next;
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        out_data <= w_scaled;
                        out_ch   <= r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mc_engine.sv
// Directed self-checking bench for fir_mc_engine (3 channels, COEF_FRAC=0).
module tb_fir_mc_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic [1:0]         in_ch;
    logic signed [15:0] in_data;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               clear;
    logic               out_valid, out_ready;
    logic [1:0]         out_ch;
    logic [15:0]        out_data;
    logic               busy, ch_err;
`ifdef FIR_SAT_EN
    logic               sat_flag;
    localparam bit      SAT = 1'b1;
`else
    localparam bit      SAT = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    fir_mc_engine #(
        .BIT_WIDTH (16),
        .FIR_ORDER (8),
        .NUM_CH    (3),
        .OUT_WIDTH (16),
        .COEF_FRAC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .busy      (busy),
        .ch_err    (ch_err)
`ifdef FIR_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Handshake one sample, check latency/data/channel; consume if out_ready is high.
    task automatic send(input logic [1:0] ch, input logic signed [15:0] d,
                        input logic [15:0] exp, input string tag);
        int unsigned edges;
        in_valid = 1'b1; in_ch = ch; in_data = d;
        tick();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check({tag, "_lat"},  64'(edges), 64'd11);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_ch"},   64'(out_ch), 64'(ch));
        if (out_ready) begin
            tick();
            check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ch",    64'(out_ch), 64'd0);
        check("rst_out_data",  64'(out_data), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_ch_err",    64'(ch_err), 64'd0);
        tick();

        // impulse: coef[k]=k+1 reproduces the coefficient sequence
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k + 1));
        for (int n = 0; n < 8; n++)
            send(2'd0, (n == 0) ? 16'sd1 : 16'sd0, 16'(n + 1), "impulse");

        // channel isolation with unity coefficients
        do_clear();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'sd1);
        for (int n = 1; n <= 3; n++) begin
            send(2'd0, 16'sd100, 16'(100 * n), "iso_ch0");
            send(2'd1, 16'sd7,   16'(7 * n),   "iso_ch1");
        end

        // backpressure: result and status held while out_ready is low
        out_ready = 1'b0;
        send(2'd0, 16'sd100, 16'd400, "bp");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data",  64'(out_data), 64'd400);
            check("bp_hold_ch",    64'(out_ch), 64'd0);
            check("bp_in_ready",   64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // clear in the 3rd MAC cycle aborts and flushes history
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(k + 1));
        in_valid = 1'b1; in_ch = 2'd0; in_data = 16'sd50;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("clr_busy_before", 64'(busy), 64'd1);
        do_clear();
        check("clr_busy_after", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("clr_no_output", 64'(seen), 64'd0);
        send(2'd0, 16'sd1, 16'd1, "clr_imp0");
        send(2'd0, 16'sd0, 16'd2, "clr_imp1");
        send(2'd0, 16'sd0, 16'd3, "clr_imp2");

        // out-of-range channel is discarded with a single ch_err pulse
        in_valid = 1'b1; in_ch = 2'd3; in_data = 16'sd55;
        tick();
        in_valid = 1'b0;
        check("badch_err",   64'(ch_err), 64'd1);
        check("badch_busy",  64'(busy), 64'd0);
        tick();
        check("badch_err_off",   64'(ch_err), 64'd0);
        check("badch_busy2",     64'(busy), 64'd0);
        check("badch_no_output", 64'(out_valid), 64'd0);

        // overflow: low 16 bits of k*0x7FFF^2 equal k; saturated build clamps
        do_clear();
`ifdef FIR_SAT_EN
        check("sat_flag_cleared", 64'(sat_flag), 64'd0);
`endif
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'sh7FFF);
        for (int n = 1; n <= 8; n++)
            send(2'd2, 16'sh7FFF, SAT ? 16'h7FFF : 16'(n), "ovf");
`ifdef FIR_SAT_EN
        check("sat_flag_set", 64'(sat_flag), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
